// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write-master arbiter: state encoding,
// camera slave address, default timing constants and the round-robin pick.
package sccb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    HOLDOFF   = 2'd3
  } arb_state_t;

  localparam logic [7:0] OV7670_WR_ADDR         = 8'h42;
  localparam int         DEFAULT_GAP_CYCLES     = 200;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 20000;
  localparam int         CNT_W                  = 16;

  // A lone requester wins outright; a tie goes to whoever was not served last.
  function automatic logic pick_owner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

// File: rtl/sccb_arb_counter.sv
// Loadable down-counter with a terminal-count flag; used for the bus-free gap
// and, when enabled, for the master-done timeout.
module sccb_arb_counter
  import sccb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sccb_arbiter.sv
// Two-requester arbiter in front of the SCCB 3-phase write master.
// Optional master-done timeout enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic [7:0] data0,
  output logic       gnt0,
  output logic       done0,
  output logic       err0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic       done1,
  output logic       err1,
  output logic       m_start,
  output logic [7:0] m_reg_addr,
  output logic [7:0] m_reg_data,
  input  logic       m_ready,
  input  logic       m_done,
  output logic       busy,
  output logic       last_owner
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_err
    $error("sccb_arbiter: GAP_CYCLES/TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_t state;
  logic       grant_sel;
  logic       abort;
  logic       gap_load;
  logic       gap_tc;

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES);
  logic to_tc;

  // Timer restarts on every grant and only runs while a write is outstanding.
  sccb_arb_counter #(.W(CNT_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == IDLE) && (req0 || req1)),
    .load_val (TO_LOAD),
    .en       ((state == ISSUE) || (state == WAIT_DONE)),
    .tc       (to_tc)
  );
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  always_comb begin
    grant_sel = pick_owner(req0, req1, last_owner);
    abort     = 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
    // A done arriving on the expiry cycle still counts as a completed write.
    abort     = to_tc && ((state == ISSUE) || ((state == WAIT_DONE) && !m_done));
`endif
    gap_load  = ((state == WAIT_DONE) && m_done) || abort;
  end

  sccb_arb_counter #(.W(CNT_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (state == HOLDOFF),
    .tc       (gap_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      m_start    <= 1'b0;
      m_reg_addr <= 8'h00;
      m_reg_data <= 8'h00;
      busy       <= 1'b0;
      last_owner <= 1'b1;
`ifdef SCCB_ARB_TIMEOUT_EN
      err0       <= 1'b0;
      err1       <= 1'b0;
`endif
    end else begin
      done0   <= 1'b0;
      done1   <= 1'b0;
      m_start <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
      err0    <= 1'b0;
      err1    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last_owner <= grant_sel;
            gnt0       <= ~grant_sel;
            gnt1       <= grant_sel;
            m_reg_addr <= grant_sel ? addr1 : addr0;
            m_reg_data <= grant_sel ? data1 : data0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SCCB_ARB_TIMEOUT_EN
          if (abort) begin
            err0  <= ~last_owner;
            err1  <= last_owner;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            state <= HOLDOFF;
          end else
`endif
          if (m_ready) begin
            m_start <= 1'b1;
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (m_done) begin
            done0 <= ~last_owner;
            done1 <= last_owner;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            state <= HOLDOFF;
          end
`ifdef SCCB_ARB_TIMEOUT_EN
          else if (abort) begin
            err0  <= ~last_owner;
            err1  <= last_owner;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            state <= HOLDOFF;
          end
`endif
        end
        HOLDOFF: begin
          // Gap counter was loaded on the way in; requests are not sampled here.
          if (gap_tc) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Randomized self-checking bench for sccb_arbiter; the bench plays both
// requesters and the SCCB master, predicting grants from a transaction model.
module tb_sccb_arbiter;

  localparam int GAP = 40;
  localparam int TO  = 100;
`ifdef SCCB_ARB_TIMEOUT_EN
  localparam int LONG_RDY  = 30;
  localparam int LONG_DONE = 30;
`else
  localparam int LONG_RDY  = 300;
  localparam int LONG_DONE = 500;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] addr0, data0, addr1, data1;
  logic       gnt0, done0, err0, gnt1, done1, err1;
  logic       m_start, m_ready, m_done, busy, last_owner;
  logic [7:0] m_reg_addr, m_reg_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit rr_last = 1'b1;

  always #5 clk = ~clk;

  sccb_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0), .done0(done0), .err0(err0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1), .done1(done1), .err1(err1),
    .m_start(m_start), .m_reg_addr(m_reg_addr), .m_reg_data(m_reg_data),
    .m_ready(m_ready), .m_done(m_done), .busy(busy), .last_owner(last_owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gap after a finished or aborted write: busy stays high for GAP cycles,
  // nothing is granted, a stray m_done is ignored, then one idle cycle.
  task automatic holdoff_check();
    for (int i = 0; i < GAP; i++) begin
      m_done = (i == GAP / 2);
      @(negedge clk);
      check("hold_busy", busy, 1);
      check("hold_gnt", {gnt1, gnt0}, 0);
      check("hold_done", {done1, done0}, 0);
      check("hold_start", m_start, 0);
    end
    m_done = 1'b0;
    @(negedge clk);
    check("gap_busy_low", busy, 0);
    check("gap_gnt", {gnt1, gnt0}, 0);
  endtask

  // One complete write, starting at a negedge with the arbiter idle and
  // req0/req1 already at their intended values.
  task automatic run_txn(input logic [7:0] a0, input logic [7:0] d0,
                         input logic [7:0] a1, input logic [7:0] d1,
                         input int rdy_dly, input int done_dly,
                         input bit nx0, input bit nx1);
    bit         w;
    logic [7:0] ea, ed;
    addr0 = a0; data0 = d0; addr1 = a1; data1 = d1;
    m_ready = (rdy_dly == 0);
    w = (req0 && req1) ? !rr_last : req1;
    rr_last = w;
    ea = w ? a1 : a0;
    ed = w ? d1 : d0;
    @(negedge clk);
    check("grant", {gnt1, gnt0}, w ? 2 : 1);
    check("grant_busy", busy, 1);
    check("grant_last_owner", last_owner, w);
    check("grant_addr", m_reg_addr, ea);
    check("grant_data", m_reg_data, ed);
    check("grant_start", m_start, 0);
    addr0 = ~a0; data0 = ~d0; addr1 = ~a1; data1 = ~d1;
    for (int i = 0; i < rdy_dly; i++) begin
      m_done = (i == 0);
      @(negedge clk);
      check("issue_start", m_start, 0);
      check("issue_done", {done1, done0}, 0);
      check("issue_gnt", {gnt1, gnt0}, w ? 2 : 1);
    end
    m_done  = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("start", m_start, 1);
    check("start_addr", m_reg_addr, ea);
    check("start_data", m_reg_data, ed);
    m_ready = 1'b0;
    for (int i = 0; i < done_dly; i++) begin
      @(negedge clk);
      check("wait_start", m_start, 0);
      check("wait_done", {done1, done0}, 0);
      check("wait_gnt", {gnt1, gnt0}, w ? 2 : 1);
    end
    m_done = 1'b1;
    @(negedge clk);
    m_done  = 1'b0;
    m_ready = 1'b1;
    check("done", {done1, done0}, w ? 2 : 1);
    check("done_err", {err1, err0}, 0);
    check("done_gnt", {gnt1, gnt0}, 0);
    check("done_busy", busy, 1);
    check("done_hold_addr", m_reg_addr, ea);
    check("done_hold_data", m_reg_data, ed);
    // Winner may re-request; a waiting loser must keep holding its request.
    if (w) begin
      req1 = nx1;
      req0 = req0 | nx0;
    end else begin
      req0 = nx0;
      req1 = req1 | nx1;
    end
    holdoff_check();
  endtask

  initial begin
    int starts;
    int p;
    int idle_n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    addr0 = 8'h00; data0 = 8'h00; addr1 = 8'h00; data1 = 8'h00;
    m_ready = 1'b0; m_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {gnt1, gnt0}, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_err", {err1, err0}, 0);
    check("rst_start", m_start, 0);
    check("rst_regs", {m_reg_addr, m_reg_data}, 0);
    check("rst_busy", busy, 0);
    check("rst_last_owner", last_owner, 1);
    rst = 1'b0;
    m_ready = 1'b1;

    starts = 0;
    repeat (1000) begin
      @(negedge clk);
      if (m_start || busy) starts++;
    end
    check("idle_no_activity", starts, 0);

    // Continuous tie: expect alternation 0,1,0,1 from reset.
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++)
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              0, $urandom_range(0, 20), t < 3, t < 3);

    // Requester 0 still waiting from the last tie: directed single write.
    req1 = 1'b0;
    run_txn(8'h12, 8'h80, 8'h34, 8'h56, 0, LONG_DONE, 1'b0, 1'b0);

    // Master busy for a long stretch after grant.
    req0 = 1'b1;
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            LONG_RDY, 3, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      if (!req0 && !req1) begin
        idle_n = $urandom_range(0, 5);
        for (int i = 0; i < idle_n; i++) begin
          @(negedge clk);
          check("rand_idle_busy", busy, 0);
          check("rand_idle_start", m_start, 0);
        end
        p = $urandom_range(1, 3);
        req0 = p[0];
        req1 = p[1];
      end
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0,
              $urandom_range(0, 40), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a write.
    req0 = 1'b1; req1 = 1'b0; m_ready = 1'b1;
    addr0 = 8'($urandom); data0 = 8'($urandom);
    @(negedge clk);
    check("mid_grant", {gnt1, gnt0}, 1);
    @(negedge clk);
    check("mid_start", m_start, 1);
    m_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", {gnt1, gnt0}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last_owner", last_owner, 1);
    check("mid_rst_regs", {m_reg_addr, m_reg_data}, 0);
    req0 = 1'b0;
    rr_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    check("mid_no_done", {done1, done0}, 0);
    check("mid_idle", busy, 0);
    @(negedge clk);
    check("mid_no_done_late", {done1, done0}, 0);
    req0 = 1'b1;
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 5, 1'b0, 1'b0);

`ifdef SCCB_ARB_TIMEOUT_EN
    // Master never reports done: requester 1 gets err1 TO cycles after start.
    req1 = 1'b1; m_ready = 1'b1;
    addr1 = 8'($urandom); data1 = 8'($urandom);
    rr_last = 1'b1;
    @(negedge clk);
    check("to_grant", {gnt1, gnt0}, 2);
    @(negedge clk);
    check("to_start", m_start, 1);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      check("to_wait_err", {err1, err0}, 0);
      check("to_wait_gnt", {gnt1, gnt0}, 2);
    end
    @(negedge clk);
    check("to_err", {err1, err0}, 2);
    check("to_no_done", {done1, done0}, 0);
    check("to_gnt_drop", {gnt1, gnt0}, 0);
    req1 = 1'b0;
    holdoff_check();
    req1 = 1'b1;
    run_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 3, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_arbiter.md
Name: sccb_arbiter

Overview:
- Shares the single SCCB 3-phase write master between two requesters.
  - Requester 0: boot-time camera configuration sequencer (ROM walker).
  - Requester 1: runtime register updater (exposure/brightness/test-pattern writes).
- Grants one requester per transaction, latches its register address/data and starts the master. It then waits for the master's write-complete pulse and enforces an inter-transaction bus-free gap.
- Sits between the config/runtime requesters and the SCCB master that drives siod/sioc.

Parameters:
- GAP_CYCLES, 200, clk cycles of bus-free holdoff after every transaction (2 us at 100 MHz); legal range 1..65535.
- TIMEOUT_CYCLES, 20000, clk cycles to wait for master done before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- req0  in  1  requester 0 request; held until done0/err0
- addr0  in  8  requester 0 camera register address
- data0  in  8  requester 0 register data
- gnt0  out  1  high while requester 0 owns the master
- done0  out  1  one-cycle pulse: requester 0 write completed
- err0  out  1  one-cycle pulse: requester 0 write aborted (timeout)
- req1, addr1, data1, gnt1, done1, err1: same as above, for requester 1
- m_start  out  1  one-cycle start pulse to SCCB master
- m_reg_addr  out  8  latched register address to master
- m_reg_data  out  8  latched register data to master
- m_ready  in  1  master idle and able to accept start
- m_done  in  1  master one-cycle pulse: full 3-phase write finished
- busy  out  1  high in any state other than IDLE
- last_owner  out  1  index of the most recent grant, used for round-robin

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - last_owner=1, so requester 0 wins the first tie.
  - Gap and timeout counters 0.
- States: IDLE, ISSUE, WAIT_DONE, HOLDOFF.
- IDLE:
  - Sample req0/req1.
  - If exactly one is high, grant it. If both are high, grant ~last_owner (round-robin).
  - On grant: latch addr/data into m_reg_addr/m_reg_data, assert gntN, update last_owner, go to ISSUE.
- ISSUE:
  - Wait for m_ready=1, then pulse m_start for exactly one cycle and go to WAIT_DONE.
  - If m_ready is already 1, the start pulse occurs the cycle after grant (grant-to-start latency 1 clk).
- WAIT_DONE:
  - On m_done=1: pulse doneN next cycle, drop gntN in the same cycle, load the gap counter, go to HOLDOFF.
  - An m_done seen in IDLE, ISSUE or HOLDOFF is ignored.
- HOLDOFF:
  - Count GAP_CYCLES, then return to IDLE. No request sampling during the gap.
  - A requester must drop reqN within GAP_CYCLES of doneN; a still-high reqN is treated as a new request.
- m_reg_addr/m_reg_data hold their latched values until the next grant; they are not cleared on done.
- Requests and address/data changes are ignored while another requester owns the master.
- Address/data changes by the owner after grant are ignored (latched copy is used).
- Reset mid-transaction: everything returns to reset values immediately. No done/err pulse is generated; the requester must re-request.
- Both requesters rising in the same cycle: round-robin rule above. Back-to-back ties alternate 0,1,0,1.

Optional Feature:
- Macro: SCCB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in ISSUE and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES without m_done: pulse errN (not doneN), drop gntN, go to HOLDOFF.
  - The counter clears on every grant.
- Undefined:
  - The arbiter waits indefinitely for m_done.
  - errN tied to 0 and the counter logic is removed.

Decomposition:
- Shared package sccb_pkg:
  - State encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2, HOLDOFF=2'd3).
  - OV7670 write slave address 8'h42.
  - Default GAP_CYCLES/TIMEOUT_CYCLES constants.
- One natural sub-module: sccb_arb_counter, a loadable down-counter with terminal-count flag. Instantiated for the gap and, when the feature is enabled, for the timeout.

Test Plan:
- Reset/idle: assert rst for 3 clk -> all outputs 0, busy=0; with no req, m_start never pulses over 1000 clk.
- Single request: req0=1, addr0=8'h12, data0=8'h80, m_ready=1 -> gnt0 next clk, m_start pulse 1 clk later with m_reg_addr=8'h12/m_reg_data=8'h80. Then drive m_done 500 clk later -> done0 one cycle; busy low exactly GAP_CYCLES+1 clk after done0.
- Tie, round-robin: req0 and req1 high continuously for 4 transactions -> grant order 0,1,0,1; no overlapping gnt0/gnt1; at least GAP_CYCLES between each m_done and the next m_start.
- Master busy: m_ready=0 for 300 clk after grant -> no m_start until m_ready rises; start exactly 1 clk after m_ready=1.
- Reset mid-write: rst during WAIT_DONE -> gnt0=0, done0 never pulses, state IDLE. After reset, re-requesting req0 is granted normally.
- Timeout (SCCB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100): req1 granted, m_done never driven -> err1 pulse 100 clk after m_start, done1 stays 0, next request granted after the gap.
